uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the UART transmit FIFO write port between NREQ byte-stream requesters, for example the CPU bus path, a hardware logger and a debug monitor.
- Grants one requester at a time and holds the grant for a whole packet, so bytes from different sources never interleave on RsTx.
- Sits between the requesters and the TX FIFO write side, and honours FIFO full as backpressure.

Parameters:
- NREQ, 4, number of requesters (2..8).
- MAX_BURST, 16, maximum bytes per grant before forced release (1..255).

Ports:
- HCLK  input  1  system clock.
- HRESETn  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  requester i has a byte on its data lane.
- req_data  input  8*NREQ  byte lanes; lane i is bits [8i+7:8i].
- req_last  input  NREQ  current byte of requester i ends its packet.
- req_ready  output  NREQ  byte of requester i is accepted this cycle.
- fifo_full  input  1  TX FIFO full flag.
- fifo_wr  output  1  TX FIFO write strobe.
- fifo_wdata  output  8  TX FIFO write data.
- grant  output  NREQ  one-hot current owner; all zero when idle.
- busy  output  1  arbiter is not in IDLE.

Behaviour:
- Reset (asynchronous, HRESETn low):
  - state = IDLE, grant = 0, busy = 0, byte counter = 0.
  - Round-robin pointer = NREQ-1, so requester 0 wins first.
  - fifo_wr = 0 and req_ready = 0 while reset is asserted.
- Reset asserted mid-packet: the packet is abandoned immediately. No partial-byte write, no recovery.
- States: IDLE, XFER (plus HDR when the optional feature is compiled in).
- IDLE:
  - If any req_valid is high, pick the first valid index searching from pointer+1 upward, with modulo-NREQ wrap.
  - Register the one-hot grant, clear the counter, go to XFER next cycle.
  - Arbitration latency is 1 cycle, and no byte is accepted in IDLE.
- XFER, combinational outputs for granted index g:
  - req_ready[g] = ~fifo_full; all other ready bits are 0.
  - fifo_wr = req_valid[g] & ~fifo_full.
  - fifo_wdata = lane g.
  - Because these are combinational, a FIFO write lands in the same cycle as the handshake.
- XFER, per accepted byte:
  - Counter increments (8-bit, saturating unneeded because release occurs at MAX_BURST).
  - Release when req_last[g] is high on an accepted byte, or when the counter reaches MAX_BURST on that byte.
  - On release: go to IDLE, pointer = g, grant is cleared next cycle.
- Hold conditions in XFER:
  - fifo_full high: no write, counter unchanged, grant held.
  - req_valid[g] low mid-packet: grant held indefinitely, no preemption. Requesters must complete their packets.
- Simultaneous requests: strict rotation. After g releases, g has lowest priority at the next arbitration.
- A requester with a single-byte packet (valid and last together) completes in one XFER cycle if the FIFO is not full.
- Back-to-back grants cost minimum 1 IDLE cycle between packets.
- fifo_wdata = 0 whenever fifo_wr = 0.

Optional Feature:
- Macro: UART_ARB_TAG_EN.
- Defined:
  - IDLE goes to HDR instead of XFER.
  - HDR drives fifo_wr = ~fifo_full and fifo_wdata = 8'h80 | index g (3-bit index).
  - All req_ready are 0 in HDR.
  - On the header write, go to XFER. If fifo_full, stay in HDR.
  - The header byte does not count toward MAX_BURST.
- Not defined: no HDR state and no header bytes; IDLE goes directly to XFER.

Test Plan:
- Reset, then req0 sends 3 bytes 0x41,0x42,0x43 with last on 0x43, fifo_full=0 -> grant=0001 one cycle after valid; fifo_wr on 3 consecutive cycles with data 0x41,0x42,0x43; busy falls, grant=0000 next cycle.
- All 4 requesters valid continuously with 1-byte packets -> grant sequence 0,1,2,3,0,1; each byte written once; one IDLE gap cycle between grants.
- req1 sends 20 bytes without last, MAX_BURST=16 -> release after byte 16; req1 re-granted after other valid requesters (or immediately if none); remaining 4 bytes sent in a second grant.
- fifo_full asserted for 5 cycles mid-packet of req2 -> req_ready[2]=0 and fifo_wr=0 for those 5 cycles; no byte lost or duplicated; packet resumes.
- HRESETn pulsed low while req3 is in XFER -> grant=0000, busy=0, fifo_wr=0 immediately; after release, req0 wins first when all are valid.
- With UART_ARB_TAG_EN, req2 sends 0x55 with last -> FIFO receives 0x82 then 0x55.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that shares the UART TX FIFO write port between NREQ
//   byte-stream requesters. A grant is held for a whole packet, so bytes from
//   different sources never interleave on the serial line. A grant ends when
//   the packet ends or when MAX_BURST bytes have been sent. FIFO full stalls
//   the transfer without dropping or repeating bytes.
//
//   Optional build macro UART_ARB_TAG_EN: before each packet, write one header
//   byte 8'h80 | owner index. The header does not count toward MAX_BURST.
//
// Ports
//   HCLK, HRESETn  clock, asynchronous active-low reset
//   req_valid[i]   requester i presents a byte on lane i (req_data[8i+7:8i])
//   req_last[i]    that byte ends requester i's packet
//   req_ready[i]   byte of requester i is accepted this cycle
//   fifo_full      TX FIFO full (backpressure)
//   fifo_wr        TX FIFO write strobe
//   fifo_wdata     TX FIFO write data (0 when fifo_wr is low)
//   grant          one-hot current owner, zero when idle
//   busy           arbiter is not idle
//
// State | meaning
// IDLE  | no owner; pick next valid requester after the round-robin pointer
// HDR   | (UART_ARB_TAG_EN only) write the owner tag byte
// XFER  | pass owner bytes to the FIFO until last byte or burst limit
module uart_tx_arbiter #(
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 16
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  input  logic              fifo_full,
  output logic              fifo_wr,
  output logic [7:0]        fifo_wdata,
  output logic [NREQ-1:0]   grant,
  output logic              busy
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_HDR  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   gidx_q, gidx_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [7:0]      cnt_q, cnt_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [IW-1:0]   cand;
  logic [7:0]      lane;

  assign lane  = req_data[{gidx_q, 3'b000} +: 8];
  assign grant = grant_q;
  assign busy  = (state_q != ST_IDLE);

  // Search starts just after the last owner, so the last owner ranks lowest.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    ptr_d      = ptr_q;
    grant_d    = grant_q;
    cnt_d      = cnt_q;
    req_ready  = '0;
    fifo_wr    = 1'b0;
    fifo_wdata = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          gidx_d  = win_idx;
          grant_d = NREQ'(1) << win_idx;
          cnt_d   = 8'd0;
`ifdef UART_ARB_TAG_EN
          state_d = ST_HDR;
`else
          state_d = ST_XFER;
`endif
        end
      end
`ifdef UART_ARB_TAG_EN
      ST_HDR: begin
        if (!fifo_full) begin
          fifo_wr    = 1'b1;
          fifo_wdata = 8'h80 | {5'b00000, 3'(gidx_q)};
          state_d    = ST_XFER;
        end
      end
`endif
      ST_XFER: begin
        req_ready[gidx_q] = ~fifo_full;
        if (req_valid[gidx_q] && !fifo_full) begin
          fifo_wr    = 1'b1;
          fifo_wdata = lane;
          cnt_d      = cnt_q + 8'd1;
          if (req_last[gidx_q] || (cnt_d == 8'(MAX_BURST))) begin
            state_d = ST_IDLE;
            grant_d = '0;
            ptr_d   = gidx_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_IDLE;
      gidx_q  <= '0;
      ptr_q   <= IW'(NREQ - 1);
      grant_q <= '0;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      gidx_q  <= gidx_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;

  localparam int NREQ      = 4;
  localparam int MAX_BURST = 16;
`ifdef UART_ARB_TAG_EN
  localparam int PKT1_CYC  = 3;
`else
  localparam int PKT1_CYC  = 2;
`endif

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              fifo_full;
  logic              fifo_wr;
  logic [7:0]        fifo_wdata;
  logic [NREQ-1:0]   grant;
  logic              busy;

  uart_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(MAX_BURST)) dut (
    .HCLK       (HCLK),
    .HRESETn    (HRESETn),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .fifo_full  (fifo_full),
    .fifo_wr    (fifo_wr),
    .fifo_wdata (fifo_wdata),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 HCLK = ~HCLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // per-requester source queues: {last, data}
  logic [8:0]      src_q [NREQ][$];
  logic [7:0]      wr_log[$];
  int              wr_cyc[$];
  int              gnt_log[$];
  int              gnt_cyc[$];
  logic [7:0]      exp_q[$];
  int              exp_g[$];
  logic [NREQ-1:0] hs_n = '0;
  logic [NREQ-1:0] grant_prev = '0;
  int              cyc = 0;

  function automatic int oh2idx(input logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < NREQ; i++) begin
      if (src_q[i].size() > 0) begin
        req_valid[i]        = 1'b1;
        req_data[i*8 +: 8]  = src_q[i][0][7:0];
        req_last[i]         = src_q[i][0][8];
      end else begin
        req_valid[i]        = 1'b0;
        req_data[i*8 +: 8]  = 8'h00;
        req_last[i]         = 1'b0;
      end
    end
  endtask

  // monitor: sample between edges
  initial forever begin
    @(negedge HCLK);
    hs_n = req_valid & req_ready;
    if (fifo_wr === 1'b1) begin
      wr_log.push_back(fifo_wdata);
      wr_cyc.push_back(cyc);
    end
    if (grant != '0 && grant != grant_prev) begin
      gnt_log.push_back(oh2idx(grant));
      gnt_cyc.push_back(cyc);
    end
    grant_prev = grant;
  end

  // source driver: retire accepted byte, present the next one
  initial forever begin
    @(posedge HCLK);
    cyc++;
    #1;
    for (int i = 0; i < NREQ; i++)
      if (hs_n[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
    drive_lanes();
  end

  task automatic clear_logs();
    wr_log.delete(); wr_cyc.delete(); gnt_log.delete(); gnt_cyc.delete();
    exp_q.delete(); exp_g.delete();
  endtask

  task automatic push_hdr(input int idx);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back(8'(8'h80 | idx));
`else
    if (idx < 0) exp_q.push_back(8'h00);
`endif
  endtask

  task automatic do_reset();
    @(posedge HCLK); #2;
    HRESETn   = 1'b0;
    fifo_full = 1'b0;
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    @(negedge HCLK); @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    clear_logs();
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    bit done = 1'b0;
    for (int c = 0; c < max_cyc && !done; c++) begin
      @(negedge HCLK);
      if (busy === 1'b0 && req_valid === '0) done = 1'b1;
    end
    check_val(tag, 32'(done), 32'd1);
  endtask

  task automatic wait_grant(input string tag, input logic [NREQ-1:0] g, input int max_cyc);
    bit seen = 1'b0;
    for (int c = 0; c < max_cyc && !seen; c++) begin
      @(negedge HCLK);
      if (grant === g) seen = 1'b1;
    end
    check_val(tag, 32'(seen), 32'd1);
  endtask

  task automatic check_log(input string tag);
    check_val({tag, "_len"}, 32'(wr_log.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wr_log.size(); i++)
      check_val($sformatf("%s_b%0d", tag, i), 32'(wr_log[i]), 32'(exp_q[i]));
  endtask

  task automatic check_gnt(input string tag);
    check_val({tag, "_n"}, 32'(gnt_log.size()), 32'(exp_g.size()));
    for (int i = 0; i < exp_g.size() && i < gnt_log.size(); i++)
      check_val($sformatf("%s_g%0d", tag, i), 32'(gnt_log[i]), 32'(exp_g[i]));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETn   = 1'b0;
    fifo_full = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // reset with a requester already valid: nothing may be accepted
    src_q[0].push_back({1'b1, 8'hAA});
    @(negedge HCLK); @(negedge HCLK);
    check_val("rst_grant", 32'(grant), 32'd0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_fifo_wr", 32'(fifo_wr), 32'd0);
    check_val("rst_ready", 32'(req_ready), 32'd0);
    check_val("rst_wdata", 32'(fifo_wdata), 32'd0);
    src_q[0].delete();
    @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    clear_logs();

    // T1: req0 sends 41 42 43, exact cycle timing
    src_q[0].push_back({1'b0, 8'h41});
    src_q[0].push_back({1'b0, 8'h42});
    src_q[0].push_back({1'b1, 8'h43});
    @(negedge HCLK);
    check_val("t1_idle_grant", 32'(grant), 32'd0);
    check_val("t1_idle_wr", 32'(fifo_wr), 32'd0);
    check_val("t1_idle_wdata", 32'(fifo_wdata), 32'd0);
    @(negedge HCLK);
`ifdef UART_ARB_TAG_EN
    check_val("t1_hdr_data", 32'(fifo_wdata), 32'h80);
    check_val("t1_hdr_ready", 32'(req_ready), 32'd0);
    @(negedge HCLK);
`endif
    check_val("t1_grant", 32'(grant), 32'b0001);
    check_val("t1_busy", 32'(busy), 32'd1);
    check_val("t1_ready", 32'(req_ready), 32'b0001);
    check_val("t1_wr0", 32'(fifo_wr), 32'd1);
    check_val("t1_d0", 32'(fifo_wdata), 32'h41);
    @(negedge HCLK);
    check_val("t1_wr1", 32'(fifo_wr), 32'd1);
    check_val("t1_d1", 32'(fifo_wdata), 32'h42);
    @(negedge HCLK);
    check_val("t1_wr2", 32'(fifo_wr), 32'd1);
    check_val("t1_d2", 32'(fifo_wdata), 32'h43);
    @(negedge HCLK);
    check_val("t1_rel_grant", 32'(grant), 32'd0);
    check_val("t1_rel_busy", 32'(busy), 32'd0);
    check_val("t1_rel_wr", 32'(fifo_wr), 32'd0);
    push_hdr(0);
    exp_q.push_back(8'h41); exp_q.push_back(8'h42); exp_q.push_back(8'h43);
    check_log("t1_log");

    // T2: all requesters, two 1-byte packets each, from reset
    do_reset();
    for (int i = 0; i < NREQ; i++) begin
      src_q[i].push_back({1'b1, 8'(8'h10 + i)});
      src_q[i].push_back({1'b1, 8'(8'h20 + i)});
    end
    wait_idle("t2_done", 100);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++) begin
        push_hdr(i);
        exp_q.push_back(8'(8'h10 + 8'h10 * r + i));
        exp_g.push_back(i);
      end
    check_log("t2_log");
    check_gnt("t2_rr");
    for (int i = 0; i + 1 < gnt_cyc.size(); i++)
      check_val($sformatf("t2_gap%0d", i), 32'(gnt_cyc[i+1] - gnt_cyc[i]), 32'(PKT1_CYC));
    clear_logs();

    // T3: req1 20-byte packet vs MAX_BURST, req3 waiting (pointer now at 3)
    for (int k = 0; k < 20; k++) src_q[1].push_back({(k == 19), 8'(8'h60 + k)});
    src_q[3].push_back({1'b0, 8'hA0});
    src_q[3].push_back({1'b1, 8'hA1});
    wait_idle("t3_done", 200);
    push_hdr(1);
    for (int k = 0; k < 16; k++) exp_q.push_back(8'(8'h60 + k));
    push_hdr(3);
    exp_q.push_back(8'hA0); exp_q.push_back(8'hA1);
    push_hdr(1);
    for (int k = 16; k < 20; k++) exp_q.push_back(8'(8'h60 + k));
    exp_g.push_back(1); exp_g.push_back(3); exp_g.push_back(1);
    check_log("t3_log");
    check_gnt("t3_rr");
    clear_logs();

    // T4: fifo_full for 5 cycles in the middle of req2's packet
    for (int k = 0; k < 6; k++) src_q[2].push_back({(k == 5), 8'(8'hC0 + k)});
    wait_grant("t4_grant", 4'b0100, 20);
`ifdef UART_ARB_TAG_EN
    @(negedge HCLK);
`endif
    @(negedge HCLK);
    @(posedge HCLK); #2;
    fifo_full = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge HCLK);
      check_val($sformatf("t4_ready%0d", c), 32'(req_ready[2]), 32'd0);
      check_val($sformatf("t4_wr%0d", c), 32'(fifo_wr), 32'd0);
      check_val($sformatf("t4_held%0d", c), 32'(grant), 32'b0100);
    end
    @(posedge HCLK); #2;
    fifo_full = 1'b0;
    wait_idle("t4_done", 50);
    push_hdr(2);
    for (int k = 0; k < 6; k++) exp_q.push_back(8'(8'hC0 + k));
    check_log("t4_log");
    clear_logs();

    // T5: reset in the middle of req3's packet
    for (int k = 0; k < 5; k++) src_q[3].push_back({(k == 4), 8'(8'hE0 + k)});
    wait_grant("t5_grant", 4'b1000, 20);
    @(negedge HCLK);
    @(posedge HCLK); #2;
    HRESETn = 1'b0;
    #1;
    check_val("t5_rst_grant", 32'(grant), 32'd0);
    check_val("t5_rst_busy", 32'(busy), 32'd0);
    check_val("t5_rst_wr", 32'(fifo_wr), 32'd0);
    check_val("t5_rst_ready", 32'(req_ready), 32'd0);
    for (int i = 0; i < NREQ; i++) src_q[i].delete();
    @(negedge HCLK); @(negedge HCLK);
    HRESETn = 1'b1;
    @(negedge HCLK);
    clear_logs();
    for (int i = 0; i < NREQ; i++) src_q[i].push_back({1'b1, 8'(8'h30 + i)});
    wait_idle("t5_done", 50);
    for (int i = 0; i < NREQ; i++) begin
      push_hdr(i);
      exp_q.push_back(8'(8'h30 + i));
      exp_g.push_back(i);
    end
    check_log("t5_log");
    check_gnt("t5_rr");
    clear_logs();

    // T6: single-byte packet from req2 (tag byte first when enabled)
    src_q[2].push_back({1'b1, 8'h55});
    wait_idle("t6_done", 20);
`ifdef UART_ARB_TAG_EN
    exp_q.push_back(8'h82);
`endif
    exp_q.push_back(8'h55);
    check_log("t6_log");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
